// File: rtl/servant_sleep_ctrl.sv
// servant_sleep_ctrl: LFOSC-domain sleep/wake sequencer that gates HFOSC and holds the core
// across a drain / sleep / settle cycle, waking on a programmable timer or an external event.
module servant_sleep_ctrl #(
    parameter int CNT_W         = 16,
    parameter int ENTRY_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sleep_req,
    input  logic [CNT_W-1:0] i_sleep_cycles,
    input  logic             i_wake_evt,
    output logic             o_hf_en,
    output logic             o_core_hold,
    output logic             o_sleeping,
    output logic [1:0]       o_wake_cause
);
    localparam int PH_MAX = ENTRY_CYCLES > SETTLE_CYCLES ? ENTRY_CYCLES : SETTLE_CYCLES;
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] ENTRY_LAST = PH_W'(ENTRY_CYCLES - 1);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SLEEP, ST_SETTLE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [1:0]             cause_q, cause_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d, evt_sync_q, evt_sync_d;
    logic                   req_prev_q;
    logic                   hf_en_q, hf_en_d, hold_q, hold_d, sleeping_q, sleeping_d;
    logic                   req_s, evt_s, req_edge, timer_done;

    assign req_s = req_sync_q[SYNC_STAGES-1];
    assign evt_s = evt_sync_q[SYNC_STAGES-1];
    assign req_edge = req_s & ~req_prev_q;
    assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], i_sleep_req};
    assign evt_sync_d = {evt_sync_q[SYNC_STAGES-2:0], i_wake_evt};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            timer_q    <= '0;
            ph_q       <= '0;
            cause_q    <= 2'b00;
            req_sync_q <= '0;
            evt_sync_q <= '0;
            req_prev_q <= 1'b0;
            hf_en_q    <= 1'b1;
            hold_q     <= 1'b0;
            sleeping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ph_q       <= ph_d;
            cause_q    <= cause_d;
            req_sync_q <= req_sync_d;
            evt_sync_q <= evt_sync_d;
            req_prev_q <= req_s;
            hf_en_q    <= hf_en_d;
            hold_q     <= hold_d;
            sleeping_q <= sleeping_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ph_d       = ph_q;
        cause_d    = cause_q;
        timer_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (req_edge && evt_s) begin
                    cause_d = 2'b10;
                end else if (req_edge) begin
                    state_d = ST_DRAIN;
                    timer_d = i_sleep_cycles;
                    cause_d = 2'b00;
                    ph_d    = '0;
                end
            end
            ST_DRAIN: begin
                if (evt_s) begin
                    state_d = ST_RUN;
                    cause_d = 2'b10;
                end else if (ph_q == ENTRY_LAST) begin
                    state_d = ST_SLEEP;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SLEEP: begin
                // A zero load never reaches 1, so only the event can wake
                timer_done = timer_q == CNT_W'(1);
                timer_d    = timer_q != '0 ? timer_q - 1'b1 : timer_q;
                if (timer_done || evt_s) begin
                    state_d = ST_SETTLE;
                    cause_d = {evt_s, timer_done};
                    ph_d    = '0;
                end
            end
            default: begin
                if (ph_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        hf_en_d    = state_q != ST_SLEEP;
        hold_d     = state_q != ST_RUN;
        sleeping_d = state_q == ST_SLEEP;
    end

    assign o_hf_en      = hf_en_q;
    assign o_core_hold  = hold_q;
    assign o_sleeping   = sleeping_q;
    assign o_wake_cause = cause_q;
endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// tb_servant_sleep_ctrl: vector table plus hand-written sleep/wake sequences; expected outputs
// are queued as each cycle's inputs are driven and checked after the following clock edge.
module tb_servant_sleep_ctrl;
    typedef struct packed {
        logic        rst;
        logic        req;
        logic [15:0] cyc;
        logic        evt;
        logic        hf;
        logic        hold;
        logic        sl;
        logic [1:0]  cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_sleep_req = 1'b0;
    logic [15:0] i_sleep_cycles = '0;
    logic        i_wake_evt = 1'b0;
    logic        o_hf_en, o_core_hold, o_sleeping;
    logic [1:0]  o_wake_cause;

    vec_t sb[$];
    vec_t tbl[19];
    vec_t e;
    int   n_vec = 0;
    int   n_err = 0;

    servant_sleep_ctrl #(.CNT_W(16), .ENTRY_CYCLES(2), .SETTLE_CYCLES(2), .SYNC_STAGES(2)) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_sleep_req(i_sleep_req),
        .i_sleep_cycles(i_sleep_cycles),
        .i_wake_evt(i_wake_evt),
        .o_hf_en(o_hf_en),
        .o_core_hold(o_core_hold),
        .o_sleeping(o_sleeping),
        .o_wake_cause(o_wake_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if ({o_hf_en, o_core_hold, o_sleeping, o_wake_cause} !== {e.hf, e.hold, e.sl, e.cause}) begin
                n_err++;
                $display("FAIL vec%0d: got hf_en=%b hold=%b sleeping=%b cause=%b, expected hf_en=%b hold=%b sleeping=%b cause=%b",
                         n_vec, o_hf_en, o_core_hold, o_sleeping, o_wake_cause, e.hf, e.hold, e.sl, e.cause);
            end
        end
    end

    task automatic drive(input vec_t v);
        @(negedge clk);
        i_rst = v.rst;
        i_sleep_req = v.req;
        i_sleep_cycles = v.cyc;
        i_wake_evt = v.evt;
        sb.push_back(v);
    endtask

    task automatic run(input int n, input logic rst, input logic req, input logic [15:0] cyc,
                       input logic evt, input logic hf, input logic hold, input logic sl,
                       input logic [1:0] cause);
        vec_t v;
        v = '{rst, req, cyc, evt, hf, hold, sl, cause};
        for (int i = 0; i < n; i++) drive(v);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        for (int i = 2; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        // request edge while the wake event is already synced high is rejected
        tbl[12] = '{1'b0, 1'b0, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        tbl[13] = '{1'b0, 1'b1, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        tbl[14] = '{1'b0, 1'b1, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        tbl[15] = '{1'b0, 1'b1, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10};
        tbl[16] = '{1'b0, 1'b0, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
        tbl[17] = '{1'b0, 1'b0, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
        tbl[18] = '{1'b0, 1'b0, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
        for (int i = 0; i < 19; i++) drive(tbl[i]);

        // timer wake after 5 cycles; sleep_cycles changed after sampling must be ignored
        run(2, 0, 1, 5, 0, 1, 0, 0, 2'b10);
        run(1, 0, 1, 5, 0, 1, 0, 0, 2'b00);
        run(2, 0, 1, 9, 0, 1, 1, 0, 2'b00);
        run(4, 0, 1, 9, 0, 0, 1, 1, 2'b00);
        run(1, 0, 1, 9, 0, 0, 1, 1, 2'b01);
        run(2, 0, 1, 9, 0, 1, 1, 0, 2'b01);
        run(2, 0, 1, 9, 0, 1, 0, 0, 2'b01);
        run(3, 0, 0, 9, 0, 1, 0, 0, 2'b01);

        // event-only wake; request level left high must not re-enter sleep
        run(2, 0, 1, 0, 0, 1, 0, 0, 2'b01);
        run(1, 0, 1, 0, 0, 1, 0, 0, 2'b00);
        run(2, 0, 1, 0, 0, 1, 1, 0, 2'b00);
        run(20, 0, 1, 0, 0, 0, 1, 1, 2'b00);
        run(2, 0, 1, 0, 1, 0, 1, 1, 2'b00);
        run(1, 0, 1, 0, 1, 0, 1, 1, 2'b10);
        run(2, 0, 1, 0, 0, 1, 1, 0, 2'b10);
        run(4, 0, 1, 0, 0, 1, 0, 0, 2'b10);
        run(3, 0, 0, 0, 0, 1, 0, 0, 2'b10);

        // synced event lands on the final timer cycle
        run(2, 0, 1, 4, 0, 1, 0, 0, 2'b10);
        run(1, 0, 1, 4, 0, 1, 0, 0, 2'b00);
        run(2, 0, 1, 4, 0, 1, 1, 0, 2'b00);
        run(1, 0, 1, 4, 0, 0, 1, 1, 2'b00);
        run(2, 0, 1, 4, 1, 0, 1, 1, 2'b00);
        run(1, 0, 1, 4, 0, 0, 1, 1, 2'b11);
        run(2, 0, 1, 4, 0, 1, 1, 0, 2'b11);
        run(2, 0, 1, 4, 0, 1, 0, 0, 2'b11);
        run(3, 0, 0, 4, 0, 1, 0, 0, 2'b11);

        // event during DRAIN aborts without gating HFOSC
        run(1, 0, 1, 5, 0, 1, 0, 0, 2'b11);
        run(1, 0, 1, 5, 1, 1, 0, 0, 2'b11);
        run(1, 0, 1, 5, 1, 1, 0, 0, 2'b00);
        run(1, 0, 1, 5, 0, 1, 1, 0, 2'b10);
        run(1, 0, 1, 5, 0, 1, 0, 0, 2'b10);
        run(3, 0, 0, 5, 0, 1, 0, 0, 2'b10);

        // reset mid-SLEEP, then a fresh request behaves normally
        run(2, 0, 1, 100, 0, 1, 0, 0, 2'b10);
        run(1, 0, 1, 100, 0, 1, 0, 0, 2'b00);
        run(2, 0, 1, 100, 0, 1, 1, 0, 2'b00);
        run(3, 0, 1, 100, 0, 0, 1, 1, 2'b00);
        run(1, 1, 1, 100, 0, 1, 0, 0, 2'b00);
        run(2, 0, 0, 100, 0, 1, 0, 0, 2'b00);
        run(2, 0, 1, 3, 0, 1, 0, 0, 2'b00);
        run(1, 0, 1, 3, 0, 1, 0, 0, 2'b00);
        run(2, 0, 1, 3, 0, 1, 1, 0, 2'b00);
        run(2, 0, 1, 3, 0, 0, 1, 1, 2'b00);
        run(1, 0, 1, 3, 0, 0, 1, 1, 2'b01);
        run(2, 0, 1, 3, 0, 1, 1, 0, 2'b01);
        run(1, 0, 1, 3, 0, 1, 0, 0, 2'b01);
        run(2, 0, 0, 3, 0, 1, 0, 0, 2'b01);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
